// File: rtl/traffic_mode_controller_if.sv
// Signal bundle between the mode controller and its environment (buttons,
// config sub-module candidates, mode enables and committed times).
interface traffic_mode_controller_if #(
  parameter int TIME_W = 7
);
  logic              buttonChangeMode;
  logic              buttonConfig;
  logic [TIME_W-1:0] greenTimeModified;
  logic [TIME_W-1:0] yellowTimeModified;
  logic [TIME_W-1:0] redTimeModified;
  logic [2:0]        enable;
  logic [TIME_W-1:0] greenTime;
  logic [TIME_W-1:0] yellowTime;
  logic [TIME_W-1:0] redTime;
  logic              modeEntry;
  logic              configSaved;
  logic              configError;
  logic [1:0]        stateDbg;

  // No valid/ready handshake here: buttons are raw asynchronous levels, the
  // candidate times are plain levels sampled during the one COMMIT cycle, and
  // modeEntry/configSaved/configError are single-cycle strobes with no back-pressure.
  modport master (
    output buttonChangeMode, buttonConfig,
    output greenTimeModified, yellowTimeModified, redTimeModified,
    input  enable, greenTime, yellowTime, redTime,
    input  modeEntry, configSaved, configError, stateDbg
  );

  modport slave (
    input  buttonChangeMode, buttonConfig,
    input  greenTimeModified, yellowTimeModified, redTimeModified,
    output enable, greenTime, yellowTime, redTime,
    output modeEntry, configSaved, configError, stateDbg
  );
endinterface

// File: rtl/traffic_mode_controller.sv
// Mode sequencer: synchronizes and debounces the two mode buttons, then runs
// the AUTO/MANUAL/CONFIG/COMMIT machine that owns the committed light times.
module traffic_mode_controller #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIME_W          = 7,
  parameter int GREEN_DEF       = 30,
  parameter int YELLOW_DEF      = 5,
  parameter int RED_DEF         = 35,
  parameter int MIN_TIME        = 1,
  parameter int MAX_TIME        = 99
) (
  input logic                     clk,
  input logic                     reset,
  traffic_mode_controller_if.slave bus
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] EN_AUTO   = 3'b100;
  localparam logic [2:0] EN_CONFIG = 3'b010;
  localparam logic [2:0] EN_MANUAL = 3'b001;

  typedef enum logic [1:0] {
    AUTO   = 2'd0,
    MANUAL = 2'd1,
    CONFIG = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Button index 0 = change-mode, 1 = config.
  logic [1:0]             rawButtons;
  logic [SYNC_STAGES-1:0] syncChain [2];
  logic [CNT_W-1:0]       stableCnt [2];
  logic [1:0]             level;
  logic [1:0]             pressEv;

  assign rawButtons = {bus.buttonConfig, bus.buttonChangeMode};

  // The press event is registered on the same edge the debounced level rises,
  // so press-to-event latency is SYNC_STAGES + DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        syncChain[b] <= '0;
        stableCnt[b] <= '0;
      end
      level   <= '0;
      pressEv <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        syncChain[b] <= (syncChain[b] << 1) | SYNC_STAGES'(rawButtons[b]);
        if (syncChain[b][SYNC_STAGES-1] != level[b]) begin
          if (stableCnt[b] == CNT_LAST) begin
            level[b]     <= syncChain[b][SYNC_STAGES-1];
            pressEv[b]   <= syncChain[b][SYNC_STAGES-1];
            stableCnt[b] <= '0;
          end else begin
            stableCnt[b] <= stableCnt[b] + CNT_W'(1);
            pressEv[b]   <= 1'b0;
          end
        end else begin
          stableCnt[b] <= '0;
          pressEv[b]   <= 1'b0;
        end
      end
    end
  end

  logic modeEv;
  logic cfgEv;

  // A simultaneous change-mode press suppresses the config press outright.
  assign modeEv = pressEv[0];
  assign cfgEv  = pressEv[1] & ~pressEv[0];

  function automatic logic inRange(input logic [TIME_W-1:0] t);
    return (t >= TIME_W'(MIN_TIME)) && (t <= TIME_W'(MAX_TIME));
  endfunction

  logic [TIME_W:0] candSum;
  logic            candOk;

  assign candSum = {1'b0, bus.greenTimeModified} + {1'b0, bus.yellowTimeModified};
  assign candOk  = inRange(bus.greenTimeModified)
                && inRange(bus.yellowTimeModified)
                && inRange(bus.redTimeModified)
                && ({1'b0, bus.redTimeModified} == candSum);

  state_t            state;
  logic [2:0]        enableR;
  logic [TIME_W-1:0] greenR;
  logic [TIME_W-1:0] yellowR;
  logic [TIME_W-1:0] redR;
  logic              modeEntryR;
  logic              configSavedR;
  logic              configErrorR;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= AUTO;
      enableR      <= EN_AUTO;
      greenR       <= TIME_W'(GREEN_DEF);
      yellowR      <= TIME_W'(YELLOW_DEF);
      redR         <= TIME_W'(RED_DEF);
      modeEntryR   <= 1'b0;
      configSavedR <= 1'b0;
      configErrorR <= 1'b0;
    end else begin
      modeEntryR   <= 1'b0;
      configSavedR <= 1'b0;
      configErrorR <= 1'b0;
      case (state)
        AUTO: begin
          if (modeEv) begin
            state      <= MANUAL;
            enableR    <= EN_MANUAL;
            modeEntryR <= 1'b1;
          end else if (cfgEv) begin
            state      <= CONFIG;
            enableR    <= EN_CONFIG;
            modeEntryR <= 1'b1;
          end
        end
        MANUAL: begin
          if (modeEv) begin
            state      <= AUTO;
            enableR    <= EN_AUTO;
            modeEntryR <= 1'b1;
          end
        end
        CONFIG: begin
          if (cfgEv) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          // enable stays at CONFIG for this cycle; only an accepted commit leaves.
          if (candOk) begin
            greenR       <= bus.greenTimeModified;
            yellowR      <= bus.yellowTimeModified;
            redR         <= bus.redTimeModified;
            configSavedR <= 1'b1;
            state        <= AUTO;
            enableR      <= EN_AUTO;
            modeEntryR   <= 1'b1;
          end else begin
            configErrorR <= 1'b1;
            state        <= CONFIG;
          end
        end
      endcase
    end
  end

  assign bus.enable      = enableR;
  assign bus.greenTime   = greenR;
  assign bus.yellowTime  = yellowR;
  assign bus.redTime     = redR;
  assign bus.modeEntry   = modeEntryR;
  assign bus.configSaved = configSavedR;
  assign bus.configError = configErrorR;
  assign bus.stateDbg    = state;

endmodule

// File: tb/tb_traffic_mode_controller.sv
// Bench for traffic_mode_controller: directed scenarios plus random button and
// candidate stimulus, checked cycle by cycle against a behavioural model.
module tb_traffic_mode_controller;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int TIME_W          = 7;
  localparam int EXP_W           = 3 + 3 * TIME_W + 3;

  localparam int M_AUTO   = 0;
  localparam int M_MANUAL = 1;
  localparam int M_CONFIG = 2;
  localparam int M_COMMIT = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  traffic_mode_controller_if #(.TIME_W(TIME_W)) bus ();

  traffic_mode_controller #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .TIME_W         (TIME_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  int nCompared   = 0;
  int nMismatched = 0;
  logic [EXP_W-1:0] expQ[$];

  task automatic checkValue(input string tag, input int got, input int exp);
    nCompared++;
    if (got != exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         mMode;
  int         mG, mY, mR;
  logic [1:0] mLevel;
  logic [1:0] mEv;
  logic [1:0] rawQ[$];   // raw button samples, oldest first
  int         candG, candY, candR;

  function automatic int enOf(input int m);
    if (m == M_AUTO)   return 4;
    if (m == M_MANUAL) return 1;
    return 2;
  endfunction

  function automatic logic [EXP_W-1:0] packExp(input int en, input int g, input int y,
                                               input int r, input bit me, input bit sv,
                                               input bit er);
    return {3'(en), TIME_W'(g), TIME_W'(y), TIME_W'(r), me, sv, er};
  endfunction

  task automatic modelReset();
    rawQ.delete();
    for (int i = 0; i < SYNC_STAGES + DEBOUNCE_CYCLES; i++) rawQ.push_back(2'b00);
    mLevel = 2'b00;
    mEv    = 2'b00;
    mMode  = M_AUTO;
    mG = 30; mY = 5; mR = 35;
    expQ.delete();
    expQ.push_back(packExp(4, 30, 5, 35, 1'b0, 1'b0, 1'b0));
  endtask

  // Advance the model across one rising edge given the inputs applied before it.
  task automatic modelStep(input logic bm, input logic bc);
    int         oldEn;
    bit         sv;
    bit         er;
    bit         allDiff;
    logic [1:0] nextEv;
    oldEn = enOf(mMode);
    sv = 1'b0;
    er = 1'b0;
    case (mMode)
      M_AUTO:   if (mEv[0]) mMode = M_MANUAL; else if (mEv[1]) mMode = M_CONFIG;
      M_MANUAL: if (mEv[0]) mMode = M_AUTO;
      M_CONFIG: if (mEv[1] && !mEv[0]) mMode = M_COMMIT;
      default: begin
        if (candG >= 1 && candG <= 99 && candY >= 1 && candY <= 99 &&
            candR >= 1 && candR <= 99 && candR == candG + candY) begin
          mG = candG; mY = candY; mR = candR;
          sv = 1'b1;
          mMode = M_AUTO;
        end else begin
          er = 1'b1;
          mMode = M_CONFIG;
        end
      end
    endcase
    // Debouncer input at this edge is the raw sample SYNC_STAGES edges old; the
    // level flips once the last DEBOUNCE_CYCLES such inputs all disagree with it.
    rawQ.push_back({bc, bm});
    if (rawQ.size() > SYNC_STAGES + DEBOUNCE_CYCLES) void'(rawQ.pop_front());
    nextEv = 2'b00;
    for (int b = 0; b < 2; b++) begin
      allDiff = 1'b1;
      for (int k = 0; k < DEBOUNCE_CYCLES; k++)
        if (rawQ[k][b] == mLevel[b]) allDiff = 1'b0;
      if (allDiff) begin
        mLevel[b] = ~mLevel[b];
        nextEv[b] = mLevel[b];
      end
    end
    mEv = nextEv;
    expQ.push_back(packExp(enOf(mMode), mG, mY, mR, enOf(mMode) != oldEn, sv, er));
  endtask

  // ---------------- driver tasks ----------------
  task automatic checkOutputs();
    logic [EXP_W-1:0] e;
    if (expQ.size() == 0) begin
      checkValue("expQEmpty", 0, 1);
      return;
    end
    e = expQ.pop_front();
    checkValue("enable",      bus.enable,      e[EXP_W-1 -: 3]);
    checkValue("oneHot",      $countones(bus.enable), 1);
    checkValue("greenTime",   bus.greenTime,   e[3*TIME_W+2 -: TIME_W]);
    checkValue("yellowTime",  bus.yellowTime,  e[2*TIME_W+2 -: TIME_W]);
    checkValue("redTime",     bus.redTime,     e[TIME_W+2 -: TIME_W]);
    checkValue("modeEntry",   bus.modeEntry,   e[2]);
    checkValue("configSaved", bus.configSaved, e[1]);
    checkValue("configError", bus.configError, e[0]);
  endtask

  task automatic tick(input logic bm, input logic bc);
    @(negedge clk);
    checkOutputs();
    bus.buttonChangeMode   = bm;
    bus.buttonConfig       = bc;
    bus.greenTimeModified  = TIME_W'(candG);
    bus.yellowTimeModified = TIME_W'(candY);
    bus.redTimeModified    = TIME_W'(candR);
    modelStep(bm, bc);
  endtask

  task automatic ticks(input logic bm, input logic bc, input int n);
    for (int i = 0; i < n; i++) tick(bm, bc);
  endtask

  task automatic checkResetState(input string tag);
    checkValue({tag, "Enable"}, bus.enable, 4);
    checkValue({tag, "Green"},  bus.greenTime, 30);
    checkValue({tag, "Yellow"}, bus.yellowTime, 5);
    checkValue({tag, "Red"},    bus.redTime, 35);
    checkValue({tag, "Pulses"}, {bus.modeEntry, bus.configSaved, bus.configError}, 0);
  endtask

  // Asserts reset mid-cycle so the clear is seen before any further edge.
  task automatic applyReset(input int holdCycles, input bit toggle);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkResetState("rstAsync");
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      if (toggle) begin
        bus.buttonChangeMode = 1'($urandom_range(0, 1));
        bus.buttonConfig     = 1'($urandom_range(0, 1));
      end
      checkResetState("rstHold");
    end
    modelReset();
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic newCandidates();
    if ($urandom_range(0, 1) == 1) begin
      candG = $urandom_range(1, 60);
      candY = $urandom_range(1, 39);
      candR = candG + candY;
    end else begin
      candG = $urandom_range(0, 127);
      candY = $urandom_range(0, 127);
      candR = ($urandom_range(0, 2) == 0) ? ((candG + candY) % 128) : $urandom_range(0, 127);
    end
  endtask

  // ---------------- stimulus ----------------
  int rej[3][3] = '{'{20, 4, 30}, '{0, 5, 5}, '{90, 20, 110}};

  initial begin
    int   lat;
    int   holdM, holdC;
    logic lvlM, lvlC;

    bus.buttonChangeMode   = 1'b0;
    bus.buttonConfig       = 1'b0;
    candG = 30; candY = 5; candR = 35;
    bus.greenTimeModified  = TIME_W'(candG);
    bus.yellowTimeModified = TIME_W'(candY);
    bus.redTimeModified    = TIME_W'(candR);

    applyReset(6, 1'b1);
    bus.buttonChangeMode = 1'b0;
    bus.buttonConfig     = 1'b0;
    releaseReset();

    // Glitch shorter than the debounce window, then a real press.
    ticks(1'b1, 1'b0, 3);
    ticks(1'b0, 1'b0, 8);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      tick(i < 10, 1'b0);
      if (lat < 0 && bus.enable == 3'b001) lat = i;
    end
    checkValue("pressLatency", lat, SYNC_STAGES + DEBOUNCE_CYCLES + 1);
    ticks(1'b1, 1'b0, 10);
    ticks(1'b0, 1'b0, 10);
    checkValue("backToAuto", bus.enable, 4);

    // Simultaneous press from AUTO, then config press in MANUAL.
    ticks(1'b1, 1'b1, 10);
    ticks(1'b0, 1'b0, 10);
    checkValue("simulPress", bus.enable, 1);
    ticks(1'b0, 1'b1, 10);
    ticks(1'b0, 1'b0, 10);
    checkValue("cfgInManual", bus.enable, 1);
    ticks(1'b1, 1'b0, 10);
    ticks(1'b0, 1'b0, 10);

    // Enter CONFIG, try three bad commits, then a good one.
    ticks(1'b0, 1'b1, 10);
    ticks(1'b0, 1'b0, 10);
    checkValue("enterConfig", bus.enable, 2);
    for (int j = 0; j < 3; j++) begin
      candG = rej[j][0]; candY = rej[j][1]; candR = rej[j][2];
      ticks(1'b0, 1'b1, 10);
      ticks(1'b0, 1'b0, 10);
      checkValue("rejectEnable", bus.enable, 2);
      checkValue("rejectGreen", bus.greenTime, 30);
    end
    candG = 20; candY = 4; candR = 24;
    ticks(1'b0, 1'b1, 10);
    ticks(1'b0, 1'b0, 10);
    checkValue("goodEnable", bus.enable, 4);
    checkValue("goodGreen", bus.greenTime, 20);
    checkValue("goodYellow", bus.yellowTime, 4);
    checkValue("goodRed", bus.redTime, 24);

    // Reset while in CONFIG with a config press mid-debounce and still held.
    ticks(1'b0, 1'b1, 10);
    ticks(1'b0, 1'b0, 6);
    ticks(1'b0, 1'b1, 4);
    applyReset(3, 1'b0);
    releaseReset();
    ticks(1'b0, 1'b1, 12);
    checkValue("redebounce", bus.enable, 2);
    checkValue("redebounceGreen", bus.greenTime, 30);
    ticks(1'b0, 1'b0, 10);

    // Random phase.
    lvlM = 1'b0; lvlC = 1'b0; holdM = 0; holdC = 0;
    for (int i = 0; i < 3000; i++) begin
      if (holdM == 0) begin lvlM = 1'($urandom_range(0, 1)); holdM = $urandom_range(1, 14); end
      if (holdC == 0) begin lvlC = 1'($urandom_range(0, 1)); holdC = $urandom_range(1, 14); end
      holdM--; holdC--;
      if ($urandom_range(0, 39) == 0) newCandidates();
      tick(lvlM, lvlC);
      if (i == 1500) begin
        applyReset(2, 1'b1);
        releaseReset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    nMismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
